pipe_reg_chain: RTL and testbench



---
 rtl/pipe_reg_chain.sv | 86 ++++++++
 tb/tb_pipe_reg_chain.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_chain.sv
// Chain of DEPTH pipeline registers with per-stage valid bits.
// Each stage can stall, flush or shift. Bubbles can read as all-zero nops.
module pipe_reg_chain #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEPTH       = 1,
    parameter bit          NEG_EDGE    = 1'b1,
    parameter bit          ZERO_BUBBLE = 1'b1,
    parameter int unsigned CW          = 4
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    input  logic             en,
    input  logic             flush,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [CW-1:0]    count,
    output logic             busy
);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [CW-1:0]    cnt;

    // Priority is flush > en > hold. A zeroed bubble never samples d,
    // so an X on d cannot leak into a stage.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_d[i] = '0;
            end
            valid_d = '0;
        end else if (en) begin
            data_d[0]  = (ZERO_BUBBLE && !d_valid) ? '0 : d;
            valid_d[0] = d_valid;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                data_d[i]  = data_q[i-1];
                valid_d[i] = valid_q[i-1];
            end
        end
    end

    if (NEG_EDGE) begin : g_neg
        always_ff @(negedge clk or negedge clrn) begin
            if (!clrn) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    data_q[i] <= '0;
                end
                valid_q <= '0;
            end else begin
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end
    end else begin : g_pos
        always_ff @(posedge clk or negedge clrn) begin
            if (!clrn) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    data_q[i] <= '0;
                end
                valid_q <= '0;
            end else begin
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end
    end

    always_comb begin
        cnt = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            cnt = cnt + CW'(valid_q[i]);
        end
    end

    assign q       = data_q[DEPTH-1];
    assign q_valid = valid_q[DEPTH-1];
    assign count   = cnt;
    assign busy    = (cnt != '0);

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed self-checking bench for pipe_reg_chain across several parameter sets.
module tb_pipe_reg_chain;

    logic clk = 1'b0;
    logic clrn;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    // DEPTH=3, falling edge, zero bubbles
    logic [31:0] d3_d, d3_q;
    logic        d3_dv, d3_en, d3_fl, d3_qv, d3_busy;
    logic [3:0]  d3_cnt;

    // DEPTH=2 bubble pair sharing inputs
    logic [31:0] b_d, b1_q, b0_q;
    logic        b_dv, b_en, b_fl, b1_qv, b0_qv, b1_busy, b0_busy;
    logic [3:0]  b1_cnt, b0_cnt;

    // DEPTH=1 edge-select pair sharing inputs
    logic [31:0] e_d, n1_q, p1_q;
    logic        e_dv, e_en, e_fl, n1_qv, p1_qv, n1_busy, p1_busy;
    logic [3:0]  n1_cnt, p1_cnt;

    pipe_reg_chain #(.WIDTH(32), .DEPTH(3), .NEG_EDGE(1'b1), .ZERO_BUBBLE(1'b1), .CW(4)) u_d3 (
        .clk(clk), .clrn(clrn), .d(d3_d), .d_valid(d3_dv), .en(d3_en), .flush(d3_fl),
        .q(d3_q), .q_valid(d3_qv), .count(d3_cnt), .busy(d3_busy)
    );

    pipe_reg_chain #(.WIDTH(32), .DEPTH(2), .NEG_EDGE(1'b1), .ZERO_BUBBLE(1'b1), .CW(4)) u_b1 (
        .clk(clk), .clrn(clrn), .d(b_d), .d_valid(b_dv), .en(b_en), .flush(b_fl),
        .q(b1_q), .q_valid(b1_qv), .count(b1_cnt), .busy(b1_busy)
    );

    pipe_reg_chain #(.WIDTH(32), .DEPTH(2), .NEG_EDGE(1'b1), .ZERO_BUBBLE(1'b0), .CW(4)) u_b0 (
        .clk(clk), .clrn(clrn), .d(b_d), .d_valid(b_dv), .en(b_en), .flush(b_fl),
        .q(b0_q), .q_valid(b0_qv), .count(b0_cnt), .busy(b0_busy)
    );

    pipe_reg_chain #(.WIDTH(32), .DEPTH(1), .NEG_EDGE(1'b1), .ZERO_BUBBLE(1'b0), .CW(4)) u_n1 (
        .clk(clk), .clrn(clrn), .d(e_d), .d_valid(e_dv), .en(e_en), .flush(e_fl),
        .q(n1_q), .q_valid(n1_qv), .count(n1_cnt), .busy(n1_busy)
    );

    pipe_reg_chain #(.WIDTH(32), .DEPTH(1), .NEG_EDGE(1'b0), .ZERO_BUBBLE(1'b0), .CW(4)) u_p1 (
        .clk(clk), .clrn(clrn), .d(e_d), .d_valid(e_dv), .en(e_en), .flush(e_fl),
        .q(p1_q), .q_valid(p1_qv), .count(p1_cnt), .busy(p1_busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nedge();
        @(negedge clk);
        #1;
    endtask

    task automatic pedge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clrn  = 1'b0;
        d3_d  = '0; d3_dv = 1'b0; d3_en = 1'b0; d3_fl = 1'b0;
        b_d   = '0; b_dv  = 1'b0; b_en  = 1'b0; b_fl  = 1'b0;
        e_d   = '0; e_dv  = 1'b0; e_en  = 1'b0; e_fl  = 1'b0;

        #3;
        check("rst_q", d3_q, 0);
        check("rst_qv", d3_qv, 0);
        check("rst_cnt", d3_cnt, 0);
        check("rst_busy", d3_busy, 0);
        check("rst_p1_q", p1_q, 0);
        nedge();
        clrn = 1'b1;

        // latency
        d3_en = 1'b1; d3_dv = 1'b1; d3_d = 32'hA5A5_0001;
        nedge();
        check("lat_e1_q", d3_q, 0);
        check("lat_e1_cnt", d3_cnt, 1);
        d3_d = 32'hA5A5_0002;
        nedge();
        d3_d = 32'hA5A5_0003;
        nedge();
        check("lat_e3_q", d3_q, 32'hA5A5_0001);
        check("lat_e3_qv", d3_qv, 1);
        check("lat_e3_cnt", d3_cnt, 3);
        check("lat_e3_busy", d3_busy, 1);

        // stall
        d3_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            d3_d  = 32'h5000_0000 + k;
            d3_dv = k[0];
            nedge();
            check("stall_q", d3_q, 32'hA5A5_0001);
            check("stall_cnt", d3_cnt, 3);
        end
        d3_en = 1'b1; d3_dv = 1'b1; d3_d = 32'hA5A5_0004;
        nedge();
        check("resume_q2", d3_q, 32'hA5A5_0002);
        d3_d = 32'hA5A5_0005;
        nedge();
        check("resume_q3", d3_q, 32'hA5A5_0003);
        check("resume_cnt", d3_cnt, 3);

        // asynchronous reset between edges
        #1 clrn = 1'b0;
        #1;
        check("midrst_q", d3_q, 0);
        check("midrst_qv", d3_qv, 0);
        check("midrst_cnt", d3_cnt, 0);
        check("midrst_busy", d3_busy, 0);
        #1 clrn = 1'b1;
        d3_en = 1'b0;
        nedge();
        check("postrst_q", d3_q, 0);
        check("postrst_cnt", d3_cnt, 0);

        // flush beats en
        d3_en = 1'b1; d3_dv = 1'b1;
        for (int k = 0; k < 3; k++) begin
            d3_d = 32'h0000_0011 + k;
            nedge();
            check("fill_cnt", d3_cnt, k + 1);
        end
        d3_fl = 1'b1; d3_d = 32'hFFFF_FFFF;
        nedge();
        check("flush_q", d3_q, 0);
        check("flush_qv", d3_qv, 0);
        check("flush_cnt", d3_cnt, 0);
        check("flush_busy", d3_busy, 0);
        // X on d with d_valid=0 must become zero bubbles
        d3_fl = 1'b0; d3_dv = 1'b0; d3_d = 'x;
        for (int k = 0; k < 3; k++) begin
            nedge();
            check("postflush_q", d3_q, 0);
            check("postflush_cnt", d3_cnt, 0);
        end
        d3_en = 1'b0; d3_d = '0;

        // bubble zeroing vs pass-through
        b_en = 1'b1; b_dv = 1'b0; b_d = 32'hDEAD_BEEF;
        nedge();
        nedge();
        check("bub_zb1_q", b1_q, 0);
        check("bub_zb1_qv", b1_qv, 0);
        check("bub_zb1_cnt", b1_cnt, 0);
        check("bub_zb0_q", b0_q, 32'hDEAD_BEEF);
        check("bub_zb0_qv", b0_qv, 0);
        b_dv = 1'b1; b_d = 32'hCAFE_0001;
        nedge();
        check("bub_mix_cnt", b1_cnt, 1);
        check("bub_mix_q", b1_q, 0);
        b_dv = 1'b0; b_d = 32'h1234_5678;
        nedge();
        check("bub_live_q", b1_q, 32'hCAFE_0001);
        check("bub_live_qv", b1_qv, 1);
        check("bub_live_zb0", b0_q, 32'hCAFE_0001);
        b_en = 1'b0;

        // edge select, DEPTH=1
        e_en = 1'b1; e_dv = 1'b1; e_d = 32'h1111_1111;
        pedge();
        check("edge_p_rise", p1_q, 32'h1111_1111);
        check("edge_n_rise", n1_q, 0);
        nedge();
        check("edge_n_fall", n1_q, 32'h1111_1111);
        check("edge_n_qv", n1_qv, 1);
        check("edge_n_cnt", n1_cnt, 1);
        check("edge_p_fall", p1_q, 32'h1111_1111);
        e_d = 32'h2222_2222;
        pedge();
        check("edge_p_rise2", p1_q, 32'h2222_2222);
        check("edge_n_rise2", n1_q, 32'h1111_1111);
        nedge();
        check("edge_n_fall2", n1_q, 32'h2222_2222);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
